// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the multi-cycle ALU. It provides the
//               opcode encodings, the FSM state encodings and the helpers that
//               classify opcodes.
//               Optional feature macro: ALU_SIGNED_DIV_EN (signed DIV/REM).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Opcode encodings
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SRL   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_AND   = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIVU  = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1101;
  localparam logic [3:0] ALU_DIV   = 4'b1110;
  localparam logic [3:0] ALU_REM   = 4'b1111;

  // FSM state encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  // Opcodes that normally run through the bit-serial mul/div datapath
  function automatic logic is_iterative(input logic [3:0] op);
    logic iter;
    case (op)
      ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: iter = 1'b1;
`ifdef ALU_SIGNED_DIV_EN
      ALU_DIV, ALU_REM:                       iter = 1'b1;
`endif
      default:                                iter = 1'b0;
    endcase
    return iter;
  endfunction

  // Opcodes whose divide-by-zero case bypasses the iterative datapath
  function automatic logic is_divide(input logic [3:0] op);
    logic div;
    case (op)
      ALU_DIVU, ALU_REMU: div = 1'b1;
`ifdef ALU_SIGNED_DIV_EN
      ALU_DIV, ALU_REM:   div = 1'b1;
`endif
      default:            div = 1'b0;
    endcase
    return div;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_core
// Description : Bit-serial datapath that handles one bit per step. It performs
//               a shift-add multiply into a 2*WIDTH accumulator and a
//               restoring divide with quotient and remainder registers.
//               Optional feature macro: ALU_SIGNED_DIV_EN adds the sign
//               fix-up needed for signed DIV/REM.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,     // asynchronous, active-low
  input  logic             load,      // capture operands, arm the counter
  input  logic             step,      // perform one iteration
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,      // the current step is the final one
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]        cnt;
  logic [3:0]           op_q;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;

`ifdef ALU_SIGNED_DIV_EN
  logic is_signed;
  logic neg_q;
  logic neg_r;

  // The divider works on magnitudes, so signed operands are made positive
  assign is_signed = (op == ALU_DIV) || (op == ALU_REM);
  assign a_mag     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Remember which results need negating once the magnitudes are done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= is_signed && a[WIDTH-1];
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // The multiply adds the multiplicand into the upper half when the LSB is set
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
  // A trial subtract whose top bit is the borrow (restore when it is set)
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  assign last = (cnt == '0);

  // Iteration state: both datapaths advance together and the FSM picks the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      op_q    <= 4'b0000;
      acc     <= '0;
      mcand   <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
    end else if (load) begin
      cnt     <= CW'(WIDTH - 1);
      op_q    <= op;
      acc     <= {{WIDTH{1'b0}}, a};
      mcand   <= b;
      divisor <= b_mag;
      rem     <= '0;
      quo     <= a_mag;
    end else if (step) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      acc <= {add_sum, acc[WIDTH-1:1]};
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result selection per latched opcode, including the sign restore
  always_comb begin
    result = '0;
    case (op_q)
      ALU_MUL:   result = acc[WIDTH-1:0];
      ALU_MULHU: result = acc[2*WIDTH-1:WIDTH];
      ALU_DIVU:  result = quo;
      ALU_REMU:  result = rem;
`ifdef ALU_SIGNED_DIV_EN
      ALU_DIV:   result = neg_q ? (~quo + 1'b1) : quo;
      ALU_REM:   result = neg_r ? (~rem + 1'b1) : rem;
`endif
      default:   result = '0;
    endcase
  end

endmodule : alu_muldiv_core
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : alu_multicycle
// Description : WIDTH-bit integer ALU with a start/busy/done handshake. It
//               completes single-cycle ops in one step. MUL/MULHU/DIVU/REMU
//               use the bit-serial core. The result and zero flag are
//               registered.
//               Optional feature macro: ALU_SIGNED_DIV_EN (opcodes 1110/1111
//               become signed DIV/REM; otherwise they return 0).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,            // asynchronous, active-low
  input  logic             start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             use_core;
  logic             accept;
  logic             go_core;
  logic             special;
  logic             core_last;
  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] comb_result;
  logic [WIDTH-1:0] fin_result;
  logic [SHW-1:0]   shamt;

  assign busy_o = (state != IDLE);
  // A request is ignored while an op is in flight and in the done_o cycle
  assign accept = start_i && !busy_o && !done_o;

`ifdef ALU_SIGNED_DIV_EN
  // Divide-by-zero and MIN/-1 are settled without iterating
  assign special = (is_divide(ALU_Operation_i) && (B_i == '0)) ||
                   (((ALU_Operation_i == ALU_DIV) || (ALU_Operation_i == ALU_REM)) &&
                    (A_i == MIN_VAL) && (B_i == '1));
`else
  // Divide-by-zero is settled without iterating
  assign special = is_divide(ALU_Operation_i) && (B_i == '0);
`endif

  assign go_core = is_iterative(ALU_Operation_i) && !special;

  alu_muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (accept && go_core),
    .step   (state == CALC),
    .op     (ALU_Operation_i),
    .a      (A_i),
    .b      (B_i),
    .last   (core_last),
    .result (core_result)
  );

  // Capture the request so the single-cycle path works from stable operands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= 4'b0000;
      a_q      <= '0;
      b_q      <= '0;
      use_core <= 1'b0;
    end else if (accept) begin
      op_q     <= ALU_Operation_i;
      a_q      <= A_i;
      b_q      <= B_i;
      use_core <= go_core;
    end
  end

  assign shamt = b_q[SHW-1:0];

  // Single-cycle ops and the non-iterating divide corner cases
  always_comb begin
    comb_result = '0;
    case (op_q)
      ALU_ADD:  comb_result = a_q + b_q;
      ALU_OR:   comb_result = a_q | b_q;
      ALU_SLL:  comb_result = a_q << shamt;
      ALU_SRL:  comb_result = a_q >> shamt;
      ALU_SUB:  comb_result = a_q - b_q;
      ALU_AND:  comb_result = a_q & b_q;
      ALU_XOR:  comb_result = a_q ^ b_q;
      ALU_SRA:  comb_result = $signed(a_q) >>> shamt;
      ALU_SLT:  comb_result = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      ALU_SLTU: comb_result = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      ALU_DIVU: comb_result = '1;                    // only reached for divisor 0
      ALU_REMU: comb_result = a_q;                   // only reached for divisor 0
`ifdef ALU_SIGNED_DIV_EN
      ALU_DIV:  comb_result = (b_q == '0) ? '1  : MIN_VAL;   // /0 or MIN/-1
      ALU_REM:  comb_result = (b_q == '0) ? a_q : '0;        // /0 or MIN/-1
`endif
      default:  comb_result = '0;
    endcase
  end

  assign fin_result = use_core ? core_result : comb_result;

  // Control FSM: IDLE -> (CALC) -> FIN -> IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= go_core ? CALC : FIN;
        CALC:    if (core_last) state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Result, zero flag and done pulse load together when leaving FIN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_o       <= 1'b0;
      ALU_Result_o <= '0;
      Zero_o       <= 1'b1;
    end else if (state == FIN) begin
      done_o       <= 1'b1;
      ALU_Result_o <= fin_result;
      Zero_o       <= (fin_result == '0);
    end else begin
      done_o       <= 1'b0;
    end
  end

endmodule : alu_multicycle
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_multicycle
// Description : Self-checking bench for alu_multicycle (WIDTH=32). It runs
//               directed vectors with literal expectations, and a reference
//               model checks every cycle.
//               Optional feature macro: ALU_SIGNED_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

  localparam int W = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  res;
  logic          zero;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .start_i         (start),
    .ALU_Operation_i (op),
    .A_i             (a),
    .B_i             (b),
    .busy_o          (busy),
    .done_o          (done),
    .ALU_Result_o    (res),
    .Zero_o          (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference arithmetic: expected result and edges from accept to done_o
  function automatic void ref_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output int lat);
    logic [63:0] p;
    logic [4:0]  s;
    p   = {32'b0, x} * {32'b0, y};
    s   = y[4:0];
    lat = 1;
    r   = 32'h0;
    case (o)
      4'd0:  r = x + y;
      4'd1:  r = x | y;
      4'd2:  r = x << s;
      4'd3:  r = x >> s;
      4'd4:  r = x - y;
      4'd5:  r = x & y;
      4'd6:  r = x ^ y;
      4'd7:  r = $signed(x) >>> s;
      4'd8:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9:  r = (x < y) ? 32'd1 : 32'd0;
      4'd10: begin r = p[31:0];  lat = 33; end
      4'd11: begin r = p[63:32]; lat = 33; end
      4'd12: if (y == 0) r = 32'hFFFF_FFFF; else begin r = x / y; lat = 33; end
      4'd13: if (y == 0) r = x;             else begin r = x % y; lat = 33; end
`ifdef ALU_SIGNED_DIV_EN
      4'd14: if (y == 0) r = 32'hFFFF_FFFF;
             else if (x == MINV && y == 32'hFFFF_FFFF) r = MINV;
             else begin r = $signed(x) / $signed(y); lat = 33; end
      4'd15: if (y == 0) r = x;
             else if (x == MINV && y == 32'hFFFF_FFFF) r = 32'h0;
             else begin r = $signed(x) % $signed(y); lat = 33; end
`endif
      default: r = 32'h0;
    endcase
  endfunction

  // Cycle model: edges left until done_o, held result, done pulse
  int          m_left;
  logic        m_done;
  logic [31:0] m_res;
  logic [31:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    logic was_done;
    logic [31:0] r;
    int lat;
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_res = 0; m_pend = 0;
    end else begin
      was_done = m_done;
      m_done   = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_res  = m_pend;
        end
      end else if (start && !was_done) begin
        ref_op(op, a, b, r, lat);
        m_pend = r;
        m_left = lat;
      end
    end
  end

  // Compare all outputs against the model on every cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
      check("model_done", {31'b0, done}, {31'b0, m_done});
      check("model_result", res, m_res);
      check("model_zero", {31'b0, zero}, {31'b0, (m_res == 0)});
    end
  end

  // Issue one op and check literal result, zero flag and latency
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                        input bit poke_mid, input bit poke_done);
    int n;
    int gaps;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    gaps = 0;
    while (!done && n < 100) begin
      if (!busy) gaps++;
      @(negedge clk);
      n++;
      if (poke_mid && n == 5) begin
        op = 4'd0; a = 32'd1; b = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check({name, "_done_seen"}, {31'b0, done}, 32'd1);
    check({name, "_latency"}, n, exp_lat);
    check({name, "_busy_gap"}, gaps, 0);
    check({name, "_result"}, res, exp);
    check({name, "_zero"}, {31'b0, zero}, {31'b0, (exp == 0)});
    if (poke_done) begin
      op = 4'd0; a = 32'd2; b = 32'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "_done_cycle_start_busy"}, {31'b0, busy}, 32'd0);
      check({name, "_done_cycle_start_res"}, res, exp);
    end
  endtask

  initial begin
    int dn;
    rst_n = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", res, 32'd0);
    check("reset_zero", {31'b0, zero}, 32'd1);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    run_op("add",      4'd0,  32'd5,           32'd7,           32'd12,          1,  0, 0);
    run_op("sub",      4'd4,  32'd3,           32'd3,           32'd0,           1,  0, 0);
    run_op("add_wrap", 4'd0,  32'hFFFF_FFFF,   32'd1,           32'd0,           1,  0, 0);
    run_op("sra",      4'd7,  32'h8000_0000,   32'h24,          32'hF800_0000,   1,  0, 0);
    run_op("sll",      4'd2,  32'd1,           32'hFFFF_FFFF,   32'h8000_0000,   1,  0, 0);
    run_op("srl",      4'd3,  32'h8000_0000,   32'h21,          32'h4000_0000,   1,  0, 0);
    run_op("and",      4'd5,  32'hF0F0,        32'hFF00,        32'hF000,        1,  0, 0);
    run_op("or",       4'd1,  32'hF0F0,        32'h0F00,        32'hFFF0,        1,  0, 0);
    run_op("xor",      4'd6,  32'hFF,          32'h0F,          32'hF0,          1,  0, 1);
    run_op("slt",      4'd8,  32'hFFFF_FFFF,   32'd1,           32'd1,           1,  0, 0);
    run_op("sltu",     4'd9,  32'hFFFF_FFFF,   32'd1,           32'd0,           1,  0, 0);
    run_op("mul",      4'd10, 32'hFFFF_FFFF,   32'd2,           32'hFFFF_FFFE,   33, 0, 0);
    run_op("mulhu",    4'd11, 32'hFFFF_FFFF,   32'd2,           32'd1,           33, 0, 0);
    run_op("mul_big",  4'd10, 32'h1234_5678,   32'h9ABC_DEF0,   32'h242D_2080,   33, 0, 0);
    run_op("divu",     4'd12, 32'd100,         32'd7,           32'd14,          33, 0, 1);
    run_op("remu",     4'd13, 32'd100,         32'd7,           32'd2,           33, 0, 0);
    run_op("divu_z",   4'd12, 32'd9,           32'd0,           32'hFFFF_FFFF,   1,  0, 0);
    run_op("remu_z",   4'd13, 32'd9,           32'd0,           32'd9,           1,  0, 0);
    run_op("divu_ign", 4'd12, 32'd100,         32'd7,           32'd14,          33, 1, 0);
`ifdef ALU_SIGNED_DIV_EN
    run_op("div",      4'd14, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   33, 0, 0);
    run_op("rem",      4'd15, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   33, 0, 0);
    run_op("rem_pos",  4'd15, 32'd7,           32'hFFFF_FFFE,   32'd1,           33, 0, 0);
    run_op("div_ovf",  4'd14, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1,  0, 0);
    run_op("rem_ovf",  4'd15, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1,  0, 0);
    run_op("div_z",    4'd14, 32'd5,           32'd0,           32'hFFFF_FFFF,   1,  0, 0);
`else
    run_op("undef_e",  4'd14, 32'hFFFF_FFF9,   32'd2,           32'd0,           1,  0, 0);
    run_op("undef_f",  4'd15, 32'd7,           32'd3,           32'd0,           1,  0, 0);
`endif
    run_op("remu_pre", 4'd13, 32'd100,         32'd7,           32'd2,           33, 0, 0);

    // Abort a DIVU mid-calculation with reset
    @(negedge clk);
    op = 4'd12; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", res, 32'd0);
    check("abort_zero", {31'b0, zero}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);

    run_op("post_abort", 4'd0, 32'd40, 32'd2, 32'd42, 1, 0, 0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_multicycle
`default_nettype wire
